// File: rtl/chip_ctrl_reg_pkg.sv
// Register offsets, field layout and handshake state type shared by the
// chip-control APB register block.
package chip_ctrl_reg_pkg;

    localparam logic [11:0] INFO_OFFS    = 12'h000;
    localparam logic [11:0] BOOTSEL_OFFS = 12'h004;
    localparam logic [11:0] CLKDIV_BASE  = 12'h010;
    localparam logic [11:0] PADMUX_BASE  = 12'h100;

    localparam int CLKDIV_RATIO_W = 8;
    localparam int CLKDIV_EN_BIT  = 8;
    localparam int PADS_PER_WORD  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HS,
        ST_DONE
    } hs_state_e;

endpackage

// File: rtl/chip_ctrl_apb_regs.sv
// APB3 slave holding pad-mux selects, clock-divider configuration (pushed out
// through a valid/ack handshake with timeout) and the boot-select capture.
module chip_ctrl_apb_regs
    import chip_ctrl_reg_pkg::*;
#(
    parameter int          N_PADS      = 48,
    parameter int          N_CLKDIV    = 3,
    parameter int          ACK_TIMEOUT = 64,
    parameter logic [31:0] VERSION     = 32'h0001_0000
) (
    input  logic                  soc_clk_i,
    input  logic                  soc_rstn_synced_i,
    input  logic [31:0]           paddr_i,
    input  logic [31:0]           pwdata_i,
    input  logic                  pwrite_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic [2:0]            pprot_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [1:0]            bootsel_i,
    output logic [2*N_PADS-1:0]   pad_mux_o,
    output logic [8*N_CLKDIV-1:0] clkdiv_value_o,
    output logic [N_CLKDIV-1:0]   clkdiv_en_o,
    output logic [N_CLKDIV-1:0]   clkdiv_valid_o,
    input  logic [N_CLKDIV-1:0]   clkdiv_ack_i
);

    localparam int N_WORDS = (N_PADS + PADS_PER_WORD - 1) / PADS_PER_WORD;
    localparam int CNT_W   = $clog2(ACK_TIMEOUT);
    localparam int IDX_W   = (N_CLKDIV > 1) ? $clog2(N_CLKDIV) : 1;
    localparam int CFG_W   = CLKDIV_RATIO_W + 1;

    hs_state_e state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [IDX_W-1:0]          idx_q;
    logic [CFG_W-1:0]          old_q;
    logic                      err_q;
    logic [CLKDIV_RATIO_W-1:0] ratio_q [N_CLKDIV];
    logic [N_CLKDIV-1:0]       en_q;
    logic [2*N_PADS-1:0]       pad_q;
    logic [1:0]                bootsel_q;
    logic                      captured_q;

    logic [11:0] offs, rel_ck, rel_pad, ck_idx, pad_widx;
    logic        hit_info, hit_boot, hit_ck, hit_pad, hit_any;
    logic        access, ck_wr, pad_wr;
    logic        hs_ack, hs_timeout;
    logic [31:0] ck_rd, pad_rd, rd_data;
    logic [CFG_W-1:0] cur_cfg;
    logic        unused_bits;

    assign unused_bits = ^{pprot_i, paddr_i[31:12]};

    // Address decode; out-of-window offsets wrap to large indices and miss.
    assign offs     = paddr_i[11:0];
    assign rel_ck   = offs - CLKDIV_BASE;
    assign rel_pad  = offs - PADMUX_BASE;
    assign ck_idx   = {2'b00, rel_ck[11:2]};
    assign pad_widx = {2'b00, rel_pad[11:2]};

    assign hit_info = (offs == INFO_OFFS);
    assign hit_boot = (offs == BOOTSEL_OFFS);
    assign hit_ck   = (offs >= CLKDIV_BASE) && (offs[1:0] == 2'b00) && (ck_idx < 12'(N_CLKDIV));
    assign hit_pad  = (offs >= PADMUX_BASE) && (offs[1:0] == 2'b00) && (pad_widx < 12'(N_WORDS));
    assign hit_any  = hit_info | hit_boot | hit_ck | hit_pad;

    assign access = psel_i & penable_i;
    assign ck_wr  = (state_q == ST_IDLE) & access & pwrite_i & hit_ck;
    assign pad_wr = (state_q == ST_IDLE) & access & pwrite_i & hit_pad;

    always_comb begin
        ck_rd   = '0;
        cur_cfg = '0;
        for (int k = 0; k < N_CLKDIV; k++) begin
            if (ck_idx == 12'(k)) begin
                cur_cfg = {en_q[k], ratio_q[k]};
                ck_rd   = 32'({en_q[k], ratio_q[k]});
            end
        end
    end

    always_comb begin
        pad_rd = '0;
        for (int p = 0; p < N_PADS; p++) begin
            if (pad_widx == 12'(p / PADS_PER_WORD)) begin
                pad_rd[2*(p % PADS_PER_WORD) +: 2] = pad_q[2*p +: 2];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit_info) begin
            rd_data = {VERSION[31:16], 8'(N_CLKDIV), 8'(N_PADS)};
        end else if (hit_boot) begin
            rd_data = {30'b0, bootsel_q};
        end else if (hit_ck) begin
            rd_data = ck_rd;
        end else if (hit_pad) begin
            rd_data = pad_rd;
        end
    end

    // Handshake FSM: next state and all APB / valid outputs.
    always_comb begin
        state_d        = state_q;
        pready_o       = 1'b0;
        pslverr_o      = 1'b0;
        prdata_o       = '0;
        clkdiv_valid_o = '0;
        hs_ack         = 1'b0;
        hs_timeout     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (pwrite_i && hit_ck) begin
                        state_d = ST_HS;
                    end else begin
                        pready_o  = 1'b1;
                        pslverr_o = ~hit_any;
                        if (!pwrite_i) begin
                            prdata_o = rd_data;
                        end
                    end
                end
            end
            ST_HS: begin
                for (int k = 0; k < N_CLKDIV; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        clkdiv_valid_o[k] = 1'b1;
                        hs_ack            = clkdiv_ack_i[k];
                    end
                end
                if (hs_ack) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    hs_timeout = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                pready_o  = 1'b1;
                pslverr_o = err_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge soc_clk_i or negedge soc_rstn_synced_i) begin
        if (!soc_rstn_synced_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            old_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (ck_wr) begin
                        idx_q <= ck_idx[IDX_W-1:0];
                        old_q <= cur_cfg;
                        cnt_q <= '0;
                        err_q <= 1'b0;
                    end
                end
                ST_HS: begin
                    if (hs_ack) begin
                        err_q <= 1'b0;
                    end else if (hs_timeout) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: cnt_q <= '0;
                default: cnt_q <= '0;
            endcase
        end
    end

    // Channel registers take the new config at the write edge so it is
    // already stable while valid is up; a timeout puts the old one back.
    always_ff @(posedge soc_clk_i or negedge soc_rstn_synced_i) begin
        if (!soc_rstn_synced_i) begin
            for (int k = 0; k < N_CLKDIV; k++) begin
                ratio_q[k] <= '0;
            end
            en_q  <= '0;
            pad_q <= '0;
        end else begin
            for (int k = 0; k < N_CLKDIV; k++) begin
                if (ck_wr && (ck_idx == 12'(k))) begin
                    {en_q[k], ratio_q[k]} <= {pwdata_i[CLKDIV_EN_BIT], pwdata_i[CLKDIV_RATIO_W-1:0]};
                end else if (hs_timeout && (idx_q == IDX_W'(k))) begin
                    {en_q[k], ratio_q[k]} <= old_q;
                end
            end
            if (pad_wr) begin
                for (int p = 0; p < N_PADS; p++) begin
                    if (pad_widx == 12'(p / PADS_PER_WORD)) begin
                        pad_q[2*p +: 2] <= pwdata_i[2*(p % PADS_PER_WORD) +: 2];
                    end
                end
            end
        end
    end

    always_ff @(posedge soc_clk_i or negedge soc_rstn_synced_i) begin
        if (!soc_rstn_synced_i) begin
            bootsel_q  <= 2'b00;
            captured_q <= 1'b0;
        end else if (!captured_q) begin
            bootsel_q  <= bootsel_i;
            captured_q <= 1'b1;
        end
    end

    always_comb begin
        clkdiv_value_o = '0;
        for (int k = 0; k < N_CLKDIV; k++) begin
            clkdiv_value_o[8*k +: 8] = ratio_q[k];
        end
    end

    assign clkdiv_en_o = en_q;
    assign pad_mux_o   = pad_q;

endmodule

// File: tb/tb_chip_ctrl_apb_regs.sv
// Self-checking bench for chip_ctrl_apb_regs: table-driven APB vectors with a
// response scoreboard, plus hand-written handshake and reset sequences.
module tb_chip_ctrl_apb_regs;

    localparam int N_PADS   = 48;
    localparam int N_CLKDIV = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [31:0]           paddr, pwdata, prdata;
    logic                  pwrite, psel, penable, pready, pslverr;
    logic [2:0]            pprot;
    logic [1:0]            bootsel;
    logic [2*N_PADS-1:0]   pad_mux;
    logic [8*N_CLKDIV-1:0] clkdiv_value;
    logic [N_CLKDIV-1:0]   clkdiv_en, clkdiv_valid, clkdiv_ack;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    int                  ack_delay = 0;
    logic [N_CLKDIV-1:0] ack_mask  = '1;
    int                  vcnt      = 0;
    int                  valid_len = 0;
    logic [N_CLKDIV-1:0] valid_seen = '0;
    logic [8*N_CLKDIV-1:0] value_snap = '0;
    logic [N_CLKDIV-1:0] en_snap = '0;
    int                  cyc;

    chip_ctrl_apb_regs dut (
        .soc_clk_i         (clk),
        .soc_rstn_synced_i (rst_n),
        .paddr_i           (paddr),
        .pwdata_i          (pwdata),
        .pwrite_i          (pwrite),
        .psel_i            (psel),
        .penable_i         (penable),
        .pprot_i           (pprot),
        .prdata_o          (prdata),
        .pready_o          (pready),
        .pslverr_o         (pslverr),
        .bootsel_i         (bootsel),
        .pad_mux_o         (pad_mux),
        .clkdiv_value_o    (clkdiv_value),
        .clkdiv_en_o       (clkdiv_en),
        .clkdiv_valid_o    (clkdiv_valid),
        .clkdiv_ack_i      (clkdiv_ack)
    );

    always #5 clk = ~clk;

    // Clock-generation stand-in: acks ack_delay cycles into a valid burst and
    // records the burst length, the channels raised and the presented config.
    initial begin
        clkdiv_ack = '0;
        forever begin
            @(negedge clk);
            if (|clkdiv_valid) begin
                if (vcnt == 0) begin
                    value_snap = clkdiv_value;
                    en_snap    = clkdiv_en;
                end
                valid_seen = valid_seen | clkdiv_valid;
                clkdiv_ack = (vcnt == ack_delay) ? ack_mask : '0;
                vcnt++;
            end else begin
                if (vcnt > 0) valid_len = vcnt;
                vcnt       = 0;
                clkdiv_ack = '0;
            end
        end
    end

    task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One APB transfer; the expected response is queued up front and popped
    // when the DUT raises pready.
    task automatic apply_stimulus(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_rd, input logic exp_err, input string name,
                                  output int cycles);
        exp_t e;
        sb_q.push_back('{rdata: exp_rd, err: exp_err, name: name});
        @(posedge clk);
        #1;
        psel = 1'b1; penable = 1'b0; paddr = {20'b0, addr}; pwrite = wr; pwdata = wdata;
        @(posedge clk);
        #1;
        penable = 1'b1;
        cycles = 1;
        @(negedge clk);
        while (!pready && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        e = sb_q.pop_front();
        if (!pready) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL %s_ready: got no pready after %0d cycles expected pready", e.name, cycles);
        end else begin
            check_output({e.name, "_rdata"}, 128'(prdata), 128'(e.rdata));
            check_output({e.name, "_err"}, 128'(pslverr), 128'(e.err));
        end
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pprot = 3'b000; bootsel = 2'b10;

        vecs.push_back('{1'b0, 12'h004, 32'h0,         32'h0000_0002, 1'b0});
        vecs.push_back('{1'b1, 12'h104, 32'hFFFF_FFFF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 12'h104, 32'h0,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b1, 12'h100, 32'h1234_5678, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 12'h100, 32'h0,         32'h1234_5678, 1'b0});
        vecs.push_back('{1'b1, 12'h108, 32'h0000_A5A5, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 12'h108, 32'h0,         32'h0000_A5A5, 1'b0});
        vecs.push_back('{1'b1, 12'h10C, 32'hDEAD_BEEF, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 12'h10C, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b0, 12'h00C, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b0, 12'h01C, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b0, 12'h012, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b1, 12'h000, 32'hFFFF_FFFF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 12'h000, 32'h0,         32'h0001_0330, 1'b0});
        vecs.push_back('{1'b1, 12'h010, 32'hFFFF_F1AB, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 12'h010, 32'h0,         32'h0000_01AB, 1'b0});
        vecs.push_back('{1'b1, 12'h018, 32'hFFFF_FE77, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 12'h018, 32'h0,         32'h0000_0077, 1'b0});
        vecs.push_back('{1'b0, 12'h014, 32'h0,         32'h0,         1'b0});

        repeat (3) @(negedge clk);
        check_output("reset_outputs", 128'({pad_mux, clkdiv_value, clkdiv_en, clkdiv_valid}), 128'(0));
        check_output("reset_apb", 128'({prdata, pready, pslverr}), 128'(0));
        #1 rst_n = 1'b1;

        apply_stimulus(1'b0, 12'h000, 32'h0, 32'h0001_0330, 1'b0, "info_read", cyc);
        check_output("info_latency", 128'(cyc), 128'(1));
        apply_stimulus(1'b0, 12'h004, 32'h0, 32'h0000_0002, 1'b0, "bootsel_read", cyc);
        bootsel = 2'b01;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err,
                           $sformatf("vec%0d_%h", i, vecs[i].addr), cyc);
        end
        check_output("pad_mux_out", 128'(pad_mux), 128'({32'h0000_A5A5, 32'hFFFF_FFFF, 32'h1234_5678}));
        check_output("clkdiv_value_out", 128'(clkdiv_value), 128'(24'h77_00_AB));
        check_output("clkdiv_en_out", 128'(clkdiv_en), 128'(3'b001));

        ack_delay = 0; ack_mask = 3'b010; valid_seen = '0;
        apply_stimulus(1'b1, 12'h014, 32'h0000_0105, 32'h0, 1'b0, "ck1_ack", cyc);
        check_output("ck1_ack_latency", 128'(cyc), 128'(3));
        check_output("ck1_ack_valid_len", 128'(valid_len), 128'(1));
        check_output("ck1_ack_valid_chan", 128'(valid_seen), 128'(3'b010));
        check_output("ck1_ack_value", 128'(value_snap[15:8]), 128'(8'h05));
        check_output("ck1_ack_en", 128'(en_snap[1]), 128'(1'b1));

        ack_delay = -1; valid_seen = '0;
        apply_stimulus(1'b1, 12'h014, 32'h0000_0033, 32'h0, 1'b1, "ck1_timeout", cyc);
        check_output("ck1_timeout_latency", 128'(cyc), 128'(66));
        check_output("ck1_timeout_valid_len", 128'(valid_len), 128'(64));
        check_output("ck1_timeout_restore", 128'({clkdiv_en[1], clkdiv_value[15:8]}), 128'(9'h105));
        apply_stimulus(1'b0, 12'h014, 32'h0, 32'h0000_0105, 1'b0, "ck1_readback", cyc);

        ack_delay = 0; ack_mask = 3'b001; valid_seen = '0;
        apply_stimulus(1'b1, 12'h018, 32'h0000_01CC, 32'h0, 1'b1, "ck2_wrong_ack", cyc);
        check_output("ck2_wrong_ack_valid_chan", 128'(valid_seen), 128'(3'b100));
        apply_stimulus(1'b0, 12'h018, 32'h0, 32'h0000_0077, 1'b0, "ck2_kept_old", cyc);

        ack_delay = 63; ack_mask = 3'b100;
        apply_stimulus(1'b1, 12'h018, 32'h0000_01CC, 32'h0, 1'b0, "ck2_ack_at_timeout", cyc);
        check_output("ck2_ack_at_timeout_latency", 128'(cyc), 128'(66));
        apply_stimulus(1'b0, 12'h018, 32'h0, 32'h0000_01CC, 1'b0, "ck2_new_value", cyc);

        ack_delay = -1;
        @(posedge clk);
        #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h010; pwrite = 1'b1; pwdata = 32'h0000_01FF;
        @(posedge clk);
        #1;
        penable = 1'b1;
        repeat (5) @(negedge clk);
        check_output("hs_valid_before_reset", 128'(clkdiv_valid), 128'(3'b001));
        #2 rst_n = 1'b0;
        #1;
        check_output("reset_valid_drop", 128'(clkdiv_valid), 128'(0));
        check_output("reset_regs_clear", 128'({pad_mux, clkdiv_value, clkdiv_en}), 128'(0));
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("post_reset_outputs", 128'({pad_mux, clkdiv_value, clkdiv_en, clkdiv_valid}), 128'(0));
        check_output("post_reset_apb", 128'({prdata, pready, pslverr}), 128'(0));
        ack_delay = 0; ack_mask = '1;
        apply_stimulus(1'b0, 12'h010, 32'h0, 32'h0, 1'b0, "post_reset_ck0", cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
